// File: rtl/split_if.sv
// Bus bundle for split: one packed master request/response pair plus N packed slave pairs.
// Request = {valid, addr, wdata, wstrb}; response = {rdata, ready}; ready is a one-cycle completion pulse.
interface split_if #(
  parameter int N_SLAVES = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32
);
  localparam int STRB_W = (DATA_W + 7) / 8;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W = DATA_W + 1;

  logic [REQ_W-1:0]           m_req;
  logic [RESP_W-1:0]          m_resp;
  logic [N_SLAVES*REQ_W-1:0]  s_req;
  logic [N_SLAVES*RESP_W-1:0] s_resp;
  logic                       err;

  // master: the environment (requester and slave models); slave: the demux itself
  modport master (output m_req, s_resp, input m_resp, s_req, err);
  modport slave  (input m_req, s_resp, output m_resp, s_req, err);
endinterface

// File: rtl/split.sv
// Address-decoded 1-to-N demux; 0-cycle request and response paths, plus slave wait states.
// Unmapped addresses and slaves that stay silent for TIMEOUT cycles are closed with ready+err.
module split #(
  parameter int N_SLAVES = 2,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int P_SLAVES = ADDR_W - 1,
  parameter int TIMEOUT  = 255
) (
  input logic   clk,
  input logic   rst_n,
  split_if.slave bus
);
  localparam int NB       = $clog2(N_SLAVES) + (($clog2(N_SLAVES) == 0) ? 1 : 0);
  localparam int STRB_W   = (DATA_W + 7) / 8;
  localparam int REQ_W    = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int RESP_W   = DATA_W + 1;
  localparam int ADDR_LSB = DATA_W + STRB_W;
  localparam int CNT_W    = ($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [NB:0]      N_MAP    = N_SLAVES[NB:0];

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t                    state, state_nxt;
  logic [NB-1:0]             sel_reg, sel_nxt, idx, route_idx;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      valid, mapped, route_en;
  logic [RESP_W-1:0]         resp_sel, m_resp_c;
  logic [N_SLAVES*REQ_W-1:0] s_req_c;
  logic                      err_c;

  assign valid  = bus.m_req[REQ_W-1];
  assign idx    = bus.m_req[ADDR_LSB+P_SLAVES -: NB];
  assign mapped = ({1'b0, idx} < N_MAP);

  // Only the selected slave sees the request and is listened to; all others get zeros.
  always_comb begin
    route_en  = rst_n && ((state == IDLE && valid && mapped) || state == WAIT);
    route_idx = (state == IDLE) ? idx : sel_reg;
    s_req_c   = '0;
    resp_sel  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (route_en && route_idx == NB'(k)) begin
        s_req_c[k*REQ_W +: REQ_W] = bus.m_req;
        resp_sel                  = bus.s_resp[k*RESP_W +: RESP_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_reg;
    cnt_nxt   = cnt;
    m_resp_c  = '0;
    err_c     = 1'b0;
    if (resp_sel[0])
      m_resp_c = resp_sel;
    case (state)
      IDLE: begin
        if (valid) begin
          if (mapped) begin
            sel_nxt = idx;
            if (!resp_sel[0]) begin
              state_nxt = WAIT;
              cnt_nxt   = '0;
            end
          end else begin
            state_nxt = ERR;
          end
        end
      end
      WAIT: begin
        // A ready landing in the last allowed cycle still wins over the timeout.
        if (resp_sel[0])
          state_nxt = IDLE;
        else if (TIMEOUT != 0 && cnt == CNT_LAST)
          state_nxt = ERR;
        else if (cnt != '1)
          cnt_nxt = cnt + 1'b1;
      end
      ERR: begin
        m_resp_c  = RESP_W'(1);
        err_c     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      m_resp_c = '0;
      err_c    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      sel_reg <= sel_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.s_req  = s_req_c;
  assign bus.m_resp = m_resp_c;
  assign bus.err    = err_c;
endmodule

// File: tb/tb_split.sv
// Directed bench for split: 3 slaves (index 3 unmapped), select field addr[31:30], TIMEOUT=4.
module tb_split;
  localparam int NS     = 3;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int TO     = 4;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  split_if #(.N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW)) bus ();

  split #(
    .N_SLAVES(NS), .DATA_W(DW), .ADDR_W(AW), .P_SLAVES(AW - 1), .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] req(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {1'b1, a, d, 4'hF};
  endfunction

  function automatic logic [REQ_W-1:0] rs(input int k);
    return bus.s_req[k*REQ_W +: REQ_W];
  endfunction

  function automatic logic sv(input int k);
    return bus.s_req[k*REQ_W + REQ_W - 1];
  endfunction

  task automatic set_resp(input int k, input logic [DW-1:0] d, input logic r);
    bus.s_resp[k*RESP_W +: RESP_W] = {d, r};
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #2;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.m_req  = '0;
    bus.s_resp = '0;
    // Reset state, with a live request that must not leak through
    bus.m_req = req(32'h8000_0010, 32'h0);
    #3;
    chk("rst_m_resp", bus.m_resp, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_s_req", bus.s_req, 0);
    bus.m_req = '0;
    #4 rst_n = 1'b1;

    // Zero-wait decode to slave 2, stray ready on slave 0
    nxt();
    bus.m_req = req(32'h8000_0010, 32'h1111);
    set_resp(2, 32'hCAFE_F00D, 1'b1);
    set_resp(0, 32'h0000_0BAD, 1'b1);
    smp();
    chk("zw_resp", bus.m_resp, {32'hCAFE_F00D, 1'b1});
    chk("zw_err", bus.err, 0);
    chk("zw_s2_req", rs(2), req(32'h8000_0010, 32'h1111));
    chk("zw_s0_idle", rs(0), 0);
    chk("zw_s1_idle", rs(1), 0);
    nxt();
    bus.m_req = '0; bus.s_resp = '0;
    smp();
    chk("zw_after", bus.m_resp, 0);

    // Slave 1 with 3 wait states, stray ready from slave 0 in cycle 2
    nxt();
    bus.m_req = req(32'h4000_0004, 32'h0000_00AB);
    smp();
    chk("ws_c0_vld", sv(1), 1);
    chk("ws_c0_resp", bus.m_resp, 0);
    nxt(); smp();
    chk("ws_c1_vld", sv(1), 1);
    nxt();
    set_resp(0, 32'h0000_DEAD, 1'b1);
    smp();
    chk("ws_c2_stray", bus.m_resp, 0);
    chk("ws_c2_vld", sv(1), 1);
    nxt();
    bus.s_resp = '0;
    set_resp(1, 32'h0000_1234, 1'b1);
    smp();
    chk("ws_c3_resp", bus.m_resp, {32'h0000_1234, 1'b1});
    chk("ws_c3_err", bus.err, 0);
    nxt();
    bus.m_req = '0; bus.s_resp = '0;
    smp();
    chk("ws_after", bus.m_resp, 0);

    // Unmapped index 3
    nxt();
    bus.m_req = req(32'hC000_0000, 32'h0);
    smp();
    chk("um_c0_s_req", bus.s_req, 0);
    chk("um_c0_resp", bus.m_resp, 0);
    nxt(); smp();
    chk("um_c1_resp", bus.m_resp, {32'h0, 1'b1});
    chk("um_c1_err", bus.err, 1);
    chk("um_c1_s_req", bus.s_req, 0);
    nxt();
    bus.m_req = req(32'h0000_0020, 32'h0);
    set_resp(0, 32'h0000_0055, 1'b1);
    smp();
    chk("um_c2_idle_resp", bus.m_resp, {32'h0000_0055, 1'b1});
    chk("um_c2_err", bus.err, 0);
    nxt();
    bus.m_req = '0; bus.s_resp = '0;

    // Timeout: slave 0 never answers, late ready afterwards
    nxt();
    bus.m_req = req(32'h0000_0100, 32'h0);
    smp();
    chk("to_c0_vld", sv(0), 1);
    for (int c = 1; c <= 4; c++) begin
      nxt(); smp();
      chk("to_wait_resp", bus.m_resp, 0);
    end
    nxt(); smp();
    chk("to_c5_resp", bus.m_resp, {32'h0, 1'b1});
    chk("to_c5_err", bus.err, 1);
    chk("to_c5_s_req", bus.s_req, 0);
    nxt();
    bus.m_req = '0;
    set_resp(0, 32'h0000_0077, 1'b1);
    smp();
    chk("to_c6_late", bus.m_resp, 0);
    chk("to_c6_err", bus.err, 0);
    nxt();
    bus.s_resp = '0;

    // Ready in the last allowed WAIT cycle wins over the timeout
    nxt();
    bus.m_req = req(32'h0000_0100, 32'h0);
    smp();
    for (int c = 1; c <= 3; c++) begin
      nxt(); smp();
      chk("tr_wait_resp", bus.m_resp, 0);
    end
    nxt();
    set_resp(0, 32'h0000_0099, 1'b1);
    smp();
    chk("tr_c4_resp", bus.m_resp, {32'h0000_0099, 1'b1});
    chk("tr_c4_err", bus.err, 0);
    nxt();
    bus.m_req = '0; bus.s_resp = '0;
    smp();
    chk("tr_c5_resp", bus.m_resp, 0);
    chk("tr_c5_err", bus.err, 0);

    // Back-to-back: slave 0 (0 waits), slave 1 (2 waits), slave 0 (1 wait)
    nxt();
    bus.m_req = req(32'h0000_0000, 32'h0);
    set_resp(0, 32'h0000_00A1, 1'b1);
    smp();
    chk("b2b_t1_resp", bus.m_resp, {32'h0000_00A1, 1'b1});
    nxt();
    bus.m_req = req(32'h4000_0000, 32'h0);
    bus.s_resp = '0;
    smp();
    chk("b2b_t2_vld1", sv(1), 1);
    chk("b2b_t2_vld0", sv(0), 0);
    chk("b2b_t2_c0", bus.m_resp, 0);
    nxt(); smp();
    chk("b2b_t2_c1", bus.m_resp, 0);
    nxt();
    set_resp(1, 32'h0000_00B2, 1'b1);
    smp();
    chk("b2b_t2_resp", bus.m_resp, {32'h0000_00B2, 1'b1});
    nxt();
    bus.m_req = req(32'h0000_0040, 32'h0);
    bus.s_resp = '0;
    smp();
    chk("b2b_t3_vld0", sv(0), 1);
    chk("b2b_t3_c0", bus.m_resp, 0);
    nxt();
    set_resp(0, 32'h0000_00C3, 1'b1);
    smp();
    chk("b2b_t3_resp", bus.m_resp, {32'h0000_00C3, 1'b1});
    nxt();
    bus.m_req = '0; bus.s_resp = '0;
    smp();
    chk("b2b_after", bus.m_resp, 0);

    // Asynchronous reset in the middle of a WAIT
    nxt();
    bus.m_req = req(32'h4000_0000, 32'h0);
    smp();
    nxt(); smp();
    chk("mr_wait_vld", sv(1), 1);
    #1 rst_n = 1'b0;
    set_resp(1, 32'h0000_00EE, 1'b1);
    #1;
    chk("mr_s_req", bus.s_req, 0);
    chk("mr_m_resp", bus.m_resp, 0);
    chk("mr_err", bus.err, 0);
    #3 rst_n = 1'b1;
    nxt();
    bus.m_req = '0;
    smp();
    chk("mr_post_resp", bus.m_resp, 0);
    nxt();
    bus.m_req = req(32'h0000_0000, 32'h0);
    smp();
    chk("mr_idle_stray", bus.m_resp, 0);
    chk("mr_idle_vld0", sv(0), 1);
    nxt();
    set_resp(0, 32'h0000_0066, 1'b1);
    smp();
    chk("mr_new_resp", bus.m_resp, {32'h0000_0066, 1'b1});
    nxt();
    bus.m_req = '0; bus.s_resp = '0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
